// File: rtl/enum_cast_pkg.sv
// Shared types for the enum cast checker.
//   state_t : scan engine states (IDLE -> SCAN -> RESP -> IDLE)
//   entry_t : one legal-encoding table entry (valid bit + encoding)
// ENTRY_W is the storage width of a table entry. Values narrower than ENTRY_W
// are zero-extended before they are stored or compared, so WIDTH must not
// exceed ENTRY_W.
package enum_cast_pkg;

   localparam int unsigned ENTRY_W = 64;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      RESP
   } state_t;

   typedef struct packed {
      logic               valid;
      logic [ENTRY_W-1:0] data;
   } entry_t;

endpackage

// File: rtl/enum_cast_match.sv
// Combinational compare of one LANES-wide group of table entries against a value.
// Ports:
//   valid : valid bit of each entry in the group
//   data  : encodings of the group, entry l in data[l*ENTRY_W +: ENTRY_W]
//   value : zero-extended value being cast
//   hit   : 1 when any valid entry of the group equals value
module enum_cast_match
   import enum_cast_pkg::*;
#(
   parameter int unsigned LANES = 2
) (
   input  logic [LANES-1:0]         valid,
   input  logic [LANES*ENTRY_W-1:0] data,
   input  logic [ENTRY_W-1:0]       value,
   output logic                     hit
);

   always_comb begin
      hit = 1'b0;
      for (int l = 0; l < int'(LANES); l++) begin
         // An invalid entry never matches, whatever its stale data holds.
         if (valid[l] && (data[l*ENTRY_W +: ENTRY_W] == value)) begin
            hit = 1'b1;
         end
      end
   end

endmodule

// File: rtl/enum_cast_checker.sv
// Runtime cast-to-enum engine. A request value is checked against a programmable
// table of legal encodings, LANES entries per cycle, exiting early on a match.
// A legal value is copied into the held enum register; an illegal one leaves it.
// Optional feature macro: ENUM_CAST_STATS_EN enables saturating pass/fail counters;
// when undefined the counters read 0 and no counter flops exist.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   tbl_we/idx/data     : table write (IDLE only), sets the entry's valid bit
//   tbl_clr             : clear all valid bits (IDLE only, wins over tbl_we)
//   tbl_ready           : table accepts writes (IDLE)
//   req_valid/ready/value : cast request stream
//   rsp_valid/ready/ok  : cast result stream, rsp_ok = value is legal
//   held_value          : held enum register
//   pass_cnt, fail_cnt  : successful / failed cast counters
module enum_cast_checker
   import enum_cast_pkg::*;
#(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned LANES       = 2,
   parameter int unsigned RESET_VALUE = 16,
   parameter int unsigned CNT_W       = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tbl_we,
   output logic                     tbl_ready,
   input  logic [$clog2(DEPTH)-1:0] tbl_idx,
   input  logic [WIDTH-1:0]         tbl_data,
   input  logic                     tbl_clr,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [WIDTH-1:0]         req_value,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic                     rsp_ok,
   output logic [WIDTH-1:0]         held_value,
   output logic [CNT_W-1:0]         pass_cnt,
   output logic [CNT_W-1:0]         fail_cnt
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   // Pointer value of the final group; reaching it without a hit means a miss.
   localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(DEPTH - LANES);

   state_t             state;
   logic [IDX_W-1:0]   ptr;
   logic [WIDTH-1:0]   value;
   entry_t             tbl [DEPTH];

   logic [LANES-1:0]         grp_valid;
   logic [LANES*ENTRY_W-1:0] grp_data;
   logic                     hit;

   assign tbl_ready = (state == IDLE);
   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);

   // Table storage. Only the valid bits are reset; data of an invalid entry is don't-care.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            tbl[i].valid <= 1'b0;
         end
      end else if (state == IDLE) begin
         if (tbl_clr) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
               tbl[i].valid <= 1'b0;
            end
         end else if (tbl_we) begin
            tbl[tbl_idx] <= '{valid: 1'b1, data: ENTRY_W'(tbl_data)};
         end
      end
   end

   // Gather the group starting at ptr; ptr is always a multiple of LANES.
   always_comb begin
      grp_valid = '0;
      grp_data  = '0;
      for (int l = 0; l < int'(LANES); l++) begin
         grp_valid[l]                   = tbl[ptr + IDX_W'(l)].valid;
         grp_data[l*ENTRY_W +: ENTRY_W] = tbl[ptr + IDX_W'(l)].data;
      end
   end

   enum_cast_match #(
      .LANES (LANES)
   ) u_match (
      .valid (grp_valid),
      .data  (grp_data),
      .value (ENTRY_W'(value)),
      .hit   (hit)
   );

   // Scan FSM with registered result and held register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         ptr        <= '0;
         value      <= '0;
         rsp_ok     <= 1'b0;
         held_value <= WIDTH'(RESET_VALUE);
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  value <= req_value;
                  ptr   <= '0;
                  state <= SCAN;
               end
            end
            SCAN: begin
               if (hit) begin
                  rsp_ok     <= 1'b1;
                  held_value <= value;
                  state      <= RESP;
               end else if (ptr == LAST_PTR) begin
                  rsp_ok <= 1'b0;
                  state  <= RESP;
               end else begin
                  ptr <= ptr + IDX_W'(LANES);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ENUM_CAST_STATS_EN
   logic [CNT_W-1:0] pass_q;
   logic [CNT_W-1:0] fail_q;

   // Counters saturate at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         pass_q <= '0;
         fail_q <= '0;
      end else if (rsp_valid && rsp_ready) begin
         if (rsp_ok) begin
            if (pass_q != '1) pass_q <= pass_q + 1'b1;
         end else begin
            if (fail_q != '1) fail_q <= fail_q + 1'b1;
         end
      end
   end

   assign pass_cnt = pass_q;
   assign fail_cnt = fail_q;
`else
   assign pass_cnt = '0;
   assign fail_cnt = '0;
`endif

endmodule

// File: tb/tb_enum_cast_checker.sv
// Self-checking bench for enum_cast_checker with a behavioural table model.
module tb_enum_cast_checker;

   localparam int WIDTH = 32;
   localparam int DEPTH = 8;
   localparam int LANES = 2;
   localparam int RESET_VALUE = 16;
   localparam int CNT_W = 2;
`ifdef ENUM_CAST_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             tbl_we = 1'b0;
   logic             tbl_ready;
   logic [2:0]       tbl_idx = '0;
   logic [WIDTH-1:0] tbl_data = '0;
   logic             tbl_clr = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [WIDTH-1:0] req_value = '0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic             rsp_ok;
   logic [WIDTH-1:0] held_value;
   logic [CNT_W-1:0] pass_cnt;
   logic [CNT_W-1:0] fail_cnt;

   int total = 0;
   int passed = 0;

   // Model: legal set as plain arrays, held value and counters.
   bit          m_valid [DEPTH];
   int unsigned m_data  [DEPTH];
   int unsigned m_held;
   int          m_pass;
   int          m_fail;

   always #5 clk = ~clk;

   enum_cast_checker #(
      .WIDTH       (WIDTH),
      .DEPTH       (DEPTH),
      .LANES       (LANES),
      .RESET_VALUE (RESET_VALUE),
      .CNT_W       (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tbl_we     (tbl_we),
      .tbl_ready  (tbl_ready),
      .tbl_idx    (tbl_idx),
      .tbl_data   (tbl_data),
      .tbl_clr    (tbl_clr),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_value  (req_value),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_ok     (rsp_ok),
      .held_value (held_value),
      .pass_cnt   (pass_cnt),
      .fail_cnt   (fail_cnt)
   );

   function automatic bit exp_ok(int unsigned v);
      for (int i = 0; i < DEPTH; i++) if (m_valid[i] && m_data[i] == v) return 1'b1;
      return 1'b0;
   endfunction

   // First matching entry decides the group; a miss scans every group.
   function automatic int exp_lat(int unsigned v);
      for (int i = 0; i < DEPTH; i++) if (m_valid[i] && m_data[i] == v) return 1 + i / LANES;
      return DEPTH / LANES;
   endfunction

   function automatic int sat_inc(int c);
      if (!STATS) return 0;
      return (c == CNT_MAX) ? c : c + 1;
   endfunction

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      m_held = RESET_VALUE;
      m_pass = 0;
      m_fail = 0;
   endtask

   task automatic write_entry(input int idx, input int unsigned data);
      tbl_we = 1'b1;
      tbl_idx = 3'(idx);
      tbl_data = data;
      @(posedge clk); #1;
      tbl_we = 1'b0;
      m_valid[idx] = 1'b1;
      m_data[idx] = data;
   endtask

   task automatic clear_table();
      tbl_clr = 1'b1;
      @(posedge clk); #1;
      tbl_clr = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
   endtask

   // Issue one cast and complete the handshake; lat = -1 when rsp_valid never rises.
   task automatic cast(input int unsigned v, output bit o_ok, output int o_lat,
                       output int unsigned o_held, output bit e_ok, output int e_lat);
      e_ok = exp_ok(v);
      e_lat = exp_lat(v);
      req_valid = 1'b1;
      req_value = v;
      @(posedge clk); #1;
      req_valid = 1'b0;
      o_lat = 0;
      while (!rsp_valid && o_lat < 20) begin
         @(posedge clk); #1;
         o_lat++;
      end
      if (!rsp_valid) o_lat = -1;
      o_ok = rsp_ok;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      o_held = held_value;
      if (e_ok) begin
         m_held = v;
         m_pass = sat_inc(m_pass);
      end else begin
         m_fail = sat_inc(m_fail);
      end
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b want 1", req_ready); else passed++;
      total++; if (tbl_ready !== 1'b1) $display("FAIL reset_tbl_ready got %b want 1", tbl_ready); else passed++;
      total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); else passed++;
      total++; if (rsp_ok !== 1'b0) $display("FAIL reset_rsp_ok got %b want 0", rsp_ok); else passed++;
      total++; if (held_value !== WIDTH'(RESET_VALUE)) $display("FAIL reset_held got %0d want %0d", held_value, RESET_VALUE); else passed++;
      total++; if (pass_cnt !== '0 || fail_cnt !== '0) $display("FAIL reset_cnt got %0d/%0d want 0/0", pass_cnt, fail_cnt); else passed++;
   endtask

   task automatic test_basic();
      bit ok, eok; int lat, elat; int unsigned held;
      write_entry(0, 10);
      write_entry(1, 11);
      write_entry(2, 16);
      cast(1, ok, lat, held, eok, elat);
      total++; if (ok !== 1'b0) $display("FAIL basic_ok_1 got %b want 0", ok); else passed++;
      total++; if (held !== 16) $display("FAIL basic_held_1 got %0d want 16", held); else passed++;
      cast(10, ok, lat, held, eok, elat);
      total++; if (ok !== 1'b1) $display("FAIL basic_ok_10 got %b want 1", ok); else passed++;
      total++; if (held !== 10) $display("FAIL basic_held_10 got %0d want 10", held); else passed++;
      total++; if (lat !== 1) $display("FAIL basic_lat_10 got %0d want 1", lat); else passed++;
   endtask

   task automatic test_sweep();
      bit ok, eok; int lat, elat; int unsigned held;
      for (int v = 0; v <= 17; v++) begin
         cast(v, ok, lat, held, eok, elat);
         total++; if (ok !== eok) $display("FAIL sweep_ok v=%0d got %b want %b", v, ok, eok); else passed++;
         total++; if (held !== m_held) $display("FAIL sweep_held v=%0d got %0d want %0d", v, held, m_held); else passed++;
         total++; if (lat !== elat) $display("FAIL sweep_lat v=%0d got %0d want %0d", v, lat, elat); else passed++;
      end
   endtask

   task automatic test_latency();
      bit ok, eok; int lat, elat; int unsigned held;
      clear_table();
      cast(0, ok, lat, held, eok, elat);
      total++; if (ok !== 1'b0) $display("FAIL empty_ok_0 got %b want 0", ok); else passed++;
      total++; if (held !== m_held) $display("FAIL empty_held got %0d want %0d", held, m_held); else passed++;
      write_entry(7, 55);
      cast(55, ok, lat, held, eok, elat);
      total++; if (ok !== 1'b1 || lat !== 4) $display("FAIL lat_last got ok=%b lat=%0d want ok=1 lat=4", ok, lat); else passed++;
      cast(99, ok, lat, held, eok, elat);
      total++; if (ok !== 1'b0 || lat !== 4) $display("FAIL lat_miss got ok=%b lat=%0d want ok=0 lat=4", ok, lat); else passed++;
      write_entry(0, 77);
      cast(77, ok, lat, held, eok, elat);
      total++; if (ok !== 1'b1 || lat !== 1) $display("FAIL lat_first got ok=%b lat=%0d want ok=1 lat=1", ok, lat); else passed++;
      write_entry(4, 77);
      write_entry(3, 42);
      cast(42, ok, lat, held, eok, elat);
      total++; if (ok !== 1'b1 || lat !== 2) $display("FAIL lat_group1 got ok=%b lat=%0d want ok=1 lat=2", ok, lat); else passed++;
   endtask

   task automatic test_stall();
      bit ok, eok; int lat, elat; int unsigned held; int w;
      clear_table();
      write_entry(0, 10);
      req_valid = 1'b1;
      req_value = 10;
      @(posedge clk); #1;
      req_valid = 1'b0;
      w = 0;
      while (!rsp_valid && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      total++; if (rsp_valid !== 1'b1) $display("FAIL stall_rsp_timeout got %b want 1", rsp_valid); else passed++;
      tbl_we = 1'b1; tbl_idx = 3'd3; tbl_data = 200;
      req_valid = 1'b1; req_value = 11;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         total++;
         if (rsp_valid !== 1'b1 || rsp_ok !== 1'b1 || req_ready !== 1'b0 || tbl_ready !== 1'b0)
            $display("FAIL stall_hold c=%0d got v=%b ok=%b rr=%b tr=%b want 1 1 0 0",
                     c, rsp_valid, rsp_ok, req_ready, tbl_ready);
         else passed++;
      end
      tbl_we = 1'b0;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      m_held = 10;
      m_pass = sat_inc(m_pass);
      total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL stall_release got v=%b rr=%b want 0 1", rsp_valid, req_ready); else passed++;
      cast(200, ok, lat, held, eok, elat);
      total++; if (ok !== 1'b0) $display("FAIL stall_write_ignored got %b want 0", ok); else passed++;
      total++; if (held !== 10) $display("FAIL stall_held got %0d want 10", held); else passed++;
   endtask

   task automatic test_clr_priority();
      bit ok, eok; int lat, elat; int unsigned held;
      tbl_clr = 1'b1; tbl_we = 1'b1; tbl_idx = 3'd4; tbl_data = 300;
      @(posedge clk); #1;
      tbl_clr = 1'b0; tbl_we = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      cast(300, ok, lat, held, eok, elat);
      total++; if (ok !== 1'b0) $display("FAIL clr_prio_300 got %b want 0", ok); else passed++;
      cast(10, ok, lat, held, eok, elat);
      total++; if (ok !== 1'b0) $display("FAIL clr_prio_10 got %b want 0", ok); else passed++;
   endtask

   task automatic test_reset_mid_scan();
      bit ok, eok; int lat, elat; int unsigned held;
      write_entry(1, 10);
      write_entry(5, 12);
      cast(12, ok, lat, held, eok, elat);
      total++; if (held !== 12) $display("FAIL rst_pre_held got %0d want 12", held); else passed++;
      req_valid = 1'b1;
      req_value = 999;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      m_held = RESET_VALUE; m_pass = 0; m_fail = 0;
      total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL rst_mid_state got rr=%b v=%b want 1 0", req_ready, rsp_valid); else passed++;
      total++; if (held_value !== WIDTH'(RESET_VALUE)) $display("FAIL rst_mid_held got %0d want %0d", held_value, RESET_VALUE); else passed++;
      cast(10, ok, lat, held, eok, elat);
      total++; if (ok !== 1'b0) $display("FAIL rst_mid_cast10 got %b want 0", ok); else passed++;
      total++; if (held !== RESET_VALUE) $display("FAIL rst_mid_cast_held got %0d want %0d", held, RESET_VALUE); else passed++;
   endtask

   task automatic test_random();
      bit ok, eok; int lat, elat; int unsigned held, v;
      do_reset();
      for (int i = 0; i < DEPTH; i++)
         if ($urandom_range(0, 3) != 0) write_entry(i, $urandom_range(0, 15));
      for (int n = 0; n < 40; n++) begin
         if (n == 20) begin
            clear_table();
            for (int i = 0; i < DEPTH; i++)
               if ($urandom_range(0, 1) != 0) write_entry(i, $urandom_range(0, 15));
         end
         v = $urandom_range(0, 20);
         cast(v, ok, lat, held, eok, elat);
         total++;
         if (ok !== eok || lat !== elat || held !== m_held)
            $display("FAIL random v=%0d got ok=%b lat=%0d held=%0d want ok=%b lat=%0d held=%0d",
                     v, ok, lat, held, eok, elat, m_held);
         else passed++;
      end
   endtask

   task automatic test_stats();
      bit ok, eok; int lat, elat; int unsigned held;
      do_reset();
      write_entry(2, 33);
      for (int n = 0; n < 5; n++) cast(100 + n, ok, lat, held, eok, elat);
      total++; if (fail_cnt !== CNT_W'(m_fail)) $display("FAIL stats_fail got %0d want %0d", fail_cnt, m_fail); else passed++;
      total++; if (pass_cnt !== CNT_W'(m_pass)) $display("FAIL stats_pass0 got %0d want %0d", pass_cnt, m_pass); else passed++;
      for (int n = 0; n < 2; n++) cast(33, ok, lat, held, eok, elat);
      total++; if (pass_cnt !== CNT_W'(m_pass)) $display("FAIL stats_pass2 got %0d want %0d", pass_cnt, m_pass); else passed++;
      for (int n = 0; n < 3; n++) cast(33, ok, lat, held, eok, elat);
      total++; if (pass_cnt !== CNT_W'(m_pass)) $display("FAIL stats_pass_sat got %0d want %0d", pass_cnt, m_pass); else passed++;
      total++; if (fail_cnt !== CNT_W'(m_fail)) $display("FAIL stats_fail_hold got %0d want %0d", fail_cnt, m_fail); else passed++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_sweep();
      test_latency();
      test_stall();
      test_clr_priority();
      test_reset_mid_scan();
      test_random();
      test_stats();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule
